mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit. Sits between the pipeline MEM stage and the word-only, multi-cycle data memory.
- Accepts one load/store per request and stalls the pipeline while the memory handshake is in flight.
- Does byte-lane selection and sign/zero extension for sub-word loads.
- Does read-modify-write for sub-word stores, because the memory only transfers full 32-bit words.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in any WAIT state before the access is abandoned with resp_err=1. 8-bit counter; legal range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  MEM stage holds a load/store; must stay stable while stall=1
- req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- req_addr  input  32  byte address
- req_wdata  input  32  store data; sub-word data is taken from the low bits
- stall  output  1  freeze the pipeline
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  extended load result; 0 for stores
- resp_err  output  1  timeout (or misalignment, see Optional Feature); valid with resp_valid
- mem_valid  output  1  request to memory
- mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}
- mem_we  output  1  write enable
- mem_wdata  output  32  write word
- mem_rdata  input  32  read word; valid while mem_status==10
- mem_status  input  2  00 ready, 01 busy, 10 done (one cycle, then 00)

Behaviour:
- Reset values: state IDLE, all outputs 0, timeout counter 0, word buffer 0. Reset mid-operation returns to IDLE on the next edge. Any access the memory already latched is not tracked.
- Byte lanes are little-endian: lane k = word[8k+7:8k].
- Halfword select: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
- States: IDLE, ISSUE_R, WAIT_R, ISSUE_W, WAIT_W, DONE.
- IDLE:
  - req_valid=1: latch op, addr and wdata.
  - SW goes to ISSUE_W with wbuf=req_wdata.
  - All other ops go to ISSUE_R.
  - stall = req_valid whenever state is not DONE.
- ISSUE_R / ISSUE_W:
  - mem_valid = (mem_status==00), combinational.
  - Advance to WAIT_R / WAIT_W on the edge where mem_valid=1.
  - Otherwise hold with mem_valid=0.
- Address and data hold: mem_addr, mem_we and mem_wdata are driven from latched registers and stay stable from ISSUE through the end of WAIT.
  - mem_we=1 only in ISSUE_W and WAIT_W.
- WAIT_R, on mem_status==10:
  - Loads: extract and extend into resp_data register, go to DONE.
  - SH/SB: merge the store lanes into the read word, store the result in wbuf, go to ISSUE_W.
- WAIT_W: on mem_status==10, go to DONE.
- DONE: lasts one cycle.
  - resp_valid=1, stall=0; the pipeline advances on this edge.
  - Next state is IDLE. The request arriving next is sampled in IDLE, giving a one-cycle bubble.
- Timeout:
  - The counter clears on entering any WAIT state and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no status 10: go to DONE with resp_err=1 and resp_data=0.
- mem_valid is never asserted outside ISSUE states. A status of 10 or 01 seen in IDLE is ignored.
- Latency with memory latency L, request accepted in cycle 0:
  - LW, LH, LB, SW: resp_valid in cycle L+3.
  - SH, SB: resp_valid in cycle 2L+5.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned request is one with LW/SW and addr[1:0]!=0, or LH/LHU/SH and addr[0]!=0.
  - It goes IDLE→DONE with no memory access; resp_valid in cycle 1, resp_err=1, resp_data=0.
- Undefined:
  - The low address bits are ignored for word ops; halfword ops use addr[1] only.
  - resp_err reports timeout only.

Test Plan (L=1, memory word 0x100 = 0x8899AABB):
- LW 0x100 → one mem_valid pulse in cycle 1; resp_valid in cycle 4, resp_data=0x8899AABB, stall=1 in cycles 0–3.
- LB 0x101 → resp_data=0xFFFFFFAA. LBU 0x101 → 0x000000AA. LH 0x102 → 0xFFFF8899. LHU 0x102 → 0x00008899.
- SB 0x103, wdata 0x00000012 → read then write; mem_valid in cycles 1 and 4; resp_valid in cycle 7; memory word = 0x1299AABB; a following LW returns that value.
- SW 0x104, wdata 0xDEADBEEF, issued back-to-back after a LW → single write; mem_we high only during the write; one-cycle bubble between the two accesses; a following LW 0x104 returns 0xDEADBEEF.
- Memory never answers, TIMEOUT_CYCLES=4 → resp_valid with resp_err=1 after 4 WAIT cycles; reset asserted during WAIT → next cycle IDLE, stall=0, mem_valid=0.
- With LSU_MISALIGN_CHECK_EN, LW 0x102 → resp_valid in cycle 1, resp_err=1, no mem_valid pulse. Without the macro, the same request returns 0x8899AABB.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit between the pipeline and a word-only, multi-cycle data memory.
// Latency (memory latency L): LW/LH/LB/SW respond in cycle L+3, SH/SB (read-modify-write) in cycle 2L+5.
// Backpressure: o_stall follows i_req_valid in every state except DONE; memory requests wait for mem_status==00.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   -> misaligned LW/SW (addr[1:0]!=0) and LH/LHU/SH (addr[0]!=0) complete in cycle 1 with
//                o_resp_err=1 and no memory access.
//   undefined -> low address bits are ignored for word ops, halfword ops use addr[1] only;
//                o_resp_err reports timeout only.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req_valid/op/addr/wdata MEM-stage request (held stable while o_stall=1)
//   o_stall                   freeze the pipeline
//   o_resp_valid/data/err     one-cycle completion pulse, extended load data, timeout/misalign error
//   o_mem_valid/addr/we/wdata request to memory (word-aligned address)
//   i_mem_rdata, i_mem_status read word and status (00 ready, 01 busy, 10 done)
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_stall,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_data,
    output logic        o_resp_err,
    output logic        o_mem_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic [1:0]  i_mem_status
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [1:0] MST_READY = 2'b00;
    localparam logic [1:0] MST_DONE  = 2'b10;

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_R,
        S_WAIT_R,
        S_ISSUE_W,
        S_WAIT_W,
        S_DONE
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wbuf;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic [7:0]  r_cnt;

    logic        w_req_misalign;
    logic        w_is_load;
    logic        w_mem_done;
    logic        w_timeout;
    logic        w_mem_valid;
    logic [7:0]  w_cnt_inc;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        w_req_misalign = 1'b0;
        case (i_req_op)
            OP_LW, OP_SW:         w_req_misalign = (i_req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: w_req_misalign = i_req_addr[0];
            default:              w_req_misalign = 1'b0;
        endcase
    end
`else
    assign w_req_misalign = 1'b0;
`endif

    assign w_is_load  = (r_op != OP_SW) && (r_op != OP_SH) && (r_op != OP_SB);
    assign w_mem_done = (i_mem_status == MST_DONE);
    assign w_cnt_inc  = r_cnt + 8'd1;
    // Counter starts at 0 on WAIT entry, so the TIMEOUT_CYCLES-th WAIT cycle is the last one.
    assign w_timeout  = (w_cnt_inc == TIMEOUT_LIM);

    // Lane extraction for loads and lane merge for sub-word stores (little-endian lanes).
    always_comb begin
        w_half      = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        w_byte      = i_mem_rdata[7:0];
        w_load_data = '0;
        w_merge     = i_mem_rdata;

        case (r_addr[1:0])
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase

        case (r_op)
            OP_LW:   w_load_data = i_mem_rdata;
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'd0, w_half};
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'd0, w_byte};
            default: w_load_data = '0;
        endcase

        // r_wbuf still holds the raw store data while the read half of RMW is in flight.
        if (r_op == OP_SH) begin
            if (r_addr[1]) begin
                w_merge[31:16] = r_wbuf[15:0];
            end else begin
                w_merge[15:0] = r_wbuf[15:0];
            end
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wbuf[7:0];
                2'd1:    w_merge[15:8]  = r_wbuf[7:0];
                2'd2:    w_merge[23:16] = r_wbuf[7:0];
                default: w_merge[31:24] = r_wbuf[7:0];
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and memory request strobe
    always_comb begin
        w_state_next = r_state;
        w_mem_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_req_misalign) begin
                        w_state_next = S_DONE;
                    end else if (i_req_op == OP_SW) begin
                        w_state_next = S_ISSUE_W;
                    end else begin
                        w_state_next = S_ISSUE_R;
                    end
                end
            end
            S_ISSUE_R: begin
                w_mem_valid = (i_mem_status == MST_READY);
                if (w_mem_valid) begin
                    w_state_next = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (w_mem_done) begin
                    w_state_next = w_is_load ? S_DONE : S_ISSUE_W;
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_ISSUE_W: begin
                w_mem_valid = (i_mem_status == MST_READY);
                if (w_mem_valid) begin
                    w_state_next = S_WAIT_W;
                end
            end
            S_WAIT_W: begin
                if (w_mem_done || w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request latch, word buffer, response registers and timeout counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op        <= OP_LW;
            r_addr      <= '0;
            r_wbuf      <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_op        <= i_req_op;
                        r_addr      <= i_req_addr;
                        r_wbuf      <= i_req_wdata;
                        r_resp_data <= '0;
                        r_resp_err  <= w_req_misalign;
                    end
                end
                S_ISSUE_R, S_ISSUE_W: begin
                    if (w_mem_valid) begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT_R, S_WAIT_W: begin
                    if (w_mem_done) begin
                        if (r_state == S_WAIT_R) begin
                            if (w_is_load) begin
                                r_resp_data <= w_load_data;
                            end else begin
                                r_wbuf <= w_merge;
                            end
                        end
                    end else if (w_timeout) begin
                        r_resp_err <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_stall      = i_req_valid && (r_state != S_DONE);
    assign o_resp_valid = (r_state == S_DONE);
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;
    assign o_mem_valid  = w_mem_valid;
    assign o_mem_addr   = {r_addr[31:2], 2'b00};
    assign o_mem_we     = (r_state == S_ISSUE_W) || (r_state == S_WAIT_W);
    assign o_mem_wdata  = r_wbuf;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int TO = 4;
    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011;
    localparam logic [2:0] LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, resp_valid, resp_err, mem_valid, mem_we;
    logic [31:0] resp_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_status;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .i_req_op     (req_op),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_stall      (stall),
        .o_resp_valid (resp_valid),
        .o_resp_data  (resp_data),
        .o_resp_err   (resp_err),
        .o_mem_valid  (mem_valid),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_mem_status (mem_status)
    );

    int checks = 0;
    int errors = 0;
    string cur_tag = "";

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int          mem_lat  = 1;
    bit          mem_dead = 1'b0;
    logic [31:0] last_data;
    logic        last_err;
    int          last_lat;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h8899AABB;
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    function automatic bit is_store(input logic [2:0] op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    function automatic bit is_misaligned(input logic [2:0] op, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return ((op == LW || op == SW) && a[1:0] != 2'b00) ||
               ((op == LH || op == LHU || op == SH) && a[0]);
`else
        return (op == 3'b000) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Reference: lanes picked by shifting, sign extension by subtracting 2^n when the top bit is set.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] w, input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
        h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
        case (op)
            LW:      return w;
            LH:      return (h >= 32'h8000) ? h - 32'h0001_0000 : h;
            LHU:     return h;
            LB:      return (b >= 32'h80) ? b - 32'h0000_0100 : b;
            LBU:     return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] old,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (op == SW) begin
            mask = 32'hFFFF_FFFF; sh = 0;
        end else if (op == SH) begin
            sh = 16 * int'(a[1]); mask = 32'h0000_FFFF << sh;
        end else begin
            sh = 8 * int'(a[1:0]); mask = 32'h0000_00FF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s [%s]: observed=0x%08h expected=0x%08h", name, cur_tag, got, exp);
        end
    endtask

    // Word memory: busy for mem_lat cycles after accepting, then status 10 for one cycle.
    initial begin : mem_model
        logic        acc, we;
        logic [31:0] a, d;
        int          busy_left;
        logic [7:0]  pend_idx;
        busy_left = 0;
        pend_idx = '0;
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        mem_status = 2'b00;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            acc = mem_valid; we = mem_we; a = mem_addr; d = mem_wdata;
            #1;
            mem_rdata = $urandom;
            if (mem_status == 2'b10) begin
                mem_status = 2'b00;
            end else if (mem_status == 2'b01) begin
                if (busy_left > 1) begin
                    busy_left--;
                end else begin
                    mem_status = 2'b10;
                    mem_rdata = mem[pend_idx];
                end
            end
            if (acc && !mem_dead) begin
                pend_idx = a[9:2];
                if (we) mem[a[9:2]] = d;
                busy_left = mem_lat;
                mem_status = 2'b01;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the response cycle.
    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] exp_data, new_word;
        logic        exp_err;
        int          exp_lat, exp_valids, exp_writes, exp_we_cycles;
        int          cyc, lat, valids, writes, we_cycles, first_valid;
        bit          done, stall_ok, addr_ok, wdata_ok;
        logic [7:0]  idx;
        cur_tag = tag;
        idx = addr[9:2];
        new_word = ref_mem[idx];
        exp_data = 32'h0; exp_err = 1'b0; exp_writes = 0; exp_we_cycles = 0;
        if (is_misaligned(op, addr)) begin
            exp_err = 1'b1; exp_lat = 1; exp_valids = 0;
        end else if (mem_dead) begin
            exp_err = 1'b1; exp_valids = 1;
            exp_lat = (op == SW) ? TO + 2 : TO + 2;
            exp_writes = (op == SW) ? 1 : 0;
            exp_we_cycles = (op == SW) ? TO + 1 : 0;
        end else if (is_store(op)) begin
            new_word = ref_store(op, ref_mem[idx], addr, wd);
            ref_mem[idx] = new_word;
            exp_lat = (op == SW) ? mem_lat + 3 : 2 * mem_lat + 5;
            exp_valids = (op == SW) ? 1 : 2;
            exp_writes = 1;
            exp_we_cycles = mem_lat + 2;
        end else begin
            exp_data = ref_load(op, ref_mem[idx], addr);
            exp_lat = mem_lat + 3;
            exp_valids = 1;
        end

        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        cyc = 0; done = 1'b0; lat = -1; valids = 0; writes = 0; we_cycles = 0; first_valid = -1;
        stall_ok = 1'b1; addr_ok = 1'b1; wdata_ok = 1'b1;
        last_data = 32'hx; last_err = 1'bx;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (mem_valid) begin
                valids++;
                if (first_valid < 0) first_valid = cyc;
                if (mem_addr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
                if (mem_we) begin
                    writes++;
                    if (mem_wdata !== new_word) wdata_ok = 1'b0;
                end
            end
            if (mem_we === 1'b1) we_cycles++;
            if (resp_valid === 1'b1) begin
                done = 1'b1; lat = cyc; last_data = resp_data; last_err = resp_err;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        last_lat = lat;

        check("resp_latency", lat, exp_lat);
        check("resp_data", last_data, exp_data);
        check("resp_err", last_err, exp_err);
        check("mem_valid_pulses", valids, exp_valids);
        check("mem_write_pulses", writes, exp_writes);
        check("mem_we_cycles", we_cycles, exp_we_cycles);
        check("stall_profile", stall_ok, 1);
        check("mem_addr_stable", addr_ok, 1);
        check("mem_wdata_word", wdata_ok, 1);
        if (exp_valids > 0) check("first_mem_valid_cycle", first_valid, 1);
    endtask

    initial begin : main
        int seen, mism;
        logic [2:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset state
        cur_tag = "reset";
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed loads, L=1
        run_req("LW_100", LW, 32'h100, 32'h0);
        check("LW_100_value", last_data, 32'h8899AABB);
        check("LW_100_latency", last_lat, 4);
        run_req("LB_101", LB, 32'h101, 32'h0);
        check("LB_101_value", last_data, 32'hFFFFFFAA);
        run_req("LBU_101", LBU, 32'h101, 32'h0);
        check("LBU_101_value", last_data, 32'h000000AA);
        run_req("LH_102", LH, 32'h102, 32'h0);
        check("LH_102_value", last_data, 32'hFFFF8899);
        run_req("LHU_102", LHU, 32'h102, 32'h0);
        check("LHU_102_value", last_data, 32'h00008899);

        // Misaligned word load
        run_req("LW_102_misaligned", LW, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("misalign_err", last_err, 1);
        check("misalign_latency", last_lat, 1);
`else
        check("misalign_ignored_value", last_data, 32'h8899AABB);
`endif

        // Sub-word store (read-modify-write)
        run_req("SB_103", SB, 32'h103, 32'h00000012);
        check("SB_103_latency", last_lat, 7);
        check("SB_103_mem_word", mem[64], 32'h1299AABB);
        run_req("LW_100_after_SB", LW, 32'h100, 32'h0);
        check("LW_after_SB_value", last_data, 32'h1299AABB);

        // Back-to-back LW then SW then LW
        run_req("LW_104", LW, 32'h104, 32'h0);
        run_req("SW_104", SW, 32'h104, 32'hDEADBEEF);
        check("SW_104_latency", last_lat, 4);
        run_req("LW_104_after_SW", LW, 32'h104, 32'h0);
        check("LW_after_SW_value", last_data, 32'hDEADBEEF);

        // Timeout with a memory that never answers
        mem_dead = 1'b1;
        run_req("LW_timeout", LW, 32'h108, 32'h0);
        check("timeout_err", last_err, 1);
        check("timeout_latency", last_lat, TO + 2);

        // Reset while waiting on a dead memory
        cur_tag = "reset_in_wait";
        req_valid = 1'b1; req_op = LW; req_addr = 32'h10C; req_wdata = 32'h0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("stall_in_wait", stall, 1);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_stall", stall, 0);
        check("post_rst_mem_valid", mem_valid, 0);
        check("post_rst_resp_valid", resp_valid, 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_valid !== 1'b0) seen++;
        end
        check("post_rst_quiet", seen, 0);
        @(posedge clk); #1;
        mem_dead = 1'b0;
        run_req("LW_after_reset", LW, 32'h104, 32'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            mem_lat = int'($urandom_range(1, 3));
            op = 3'($urandom_range(0, 7));
            addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            run_req($sformatf("rand_%0d", n), op, addr, $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        cur_tag = "final_memory";
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("memory_image", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
